// File: rtl/act_pkg.sv
// act_pkg: shared types and constants for the activation stage.
//   act_mode_e  : per-frame activation function select
//   act_state_e : frame-tracking FSM state (exported on act_pipe.dbg_state)
//   CNT_W       : width of the per-frame altered-lane counter
//   sat_add     : saturating add used by the frame counters
package act_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_CLIP   = 2'd2,
    ACT_LEAKY  = 2'd3
  } act_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } act_state_e;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane: combinational activation of one signed lane.
//   x_i       : signed input lane
//   mode_i    : bypass / ReLU / clipped ReLU / leaky ReLU
//   clip_i    : signed upper bound for clipped ReLU
//   shift_i   : arithmetic right shift applied to negative lanes in leaky mode
//   y_o       : activated lane, same width as x_i
//   altered_o : lane output differs from input in ReLU or clipped-ReLU mode
module act_lane
  import act_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pSHIFT_W    = 5
) (
  input  logic signed [pDATA_WIDTH-1:0] x_i,
  input  act_mode_e                     mode_i,
  input  logic signed [pDATA_WIDTH-1:0] clip_i,
  input  logic        [pSHIFT_W-1:0]    shift_i,
  output logic signed [pDATA_WIDTH-1:0] y_o,
  output logic                          altered_o
);

  logic x_neg;
  logic clip_neg;

  assign x_neg    = x_i[pDATA_WIDTH-1];
  assign clip_neg = clip_i[pDATA_WIDTH-1];

  always_comb begin
    y_o = x_i;
    case (mode_i)
      ACT_BYPASS: y_o = x_i;
      ACT_RELU: begin
        if (x_neg) y_o = '0;
      end
      ACT_CLIP: begin
        // A negative bound leaves no legal non-negative output, so force 0.
        if (clip_neg || x_neg) y_o = '0;
        else if (x_i > clip_i) y_o = clip_i;
      end
      ACT_LEAKY: begin
        // >>> on a signed operand floors; shifts past the width give -1.
        if (x_neg) y_o = x_i >>> shift_i;
      end
    endcase
  end

  assign altered_o = ((mode_i == ACT_RELU) || (mode_i == ACT_CLIP)) && (y_o != x_i);

endmodule

// File: rtl/act_pipe.sv
// act_pipe: multi-lane activation stage with a 2-deep valid/ready pipeline.
//   clk, rst        : clock, synchronous active-high reset
//   cfg_mode/clip/shift : activation config, captured on the first beat of a frame
//   in_valid/in_ready/in_data/in_last     : upstream beat interface
//   out_valid/out_ready/out_data/out_last : downstream beat interface
//   frame_zero_cnt  : lanes zeroed or clipped in the last completed frame (saturating)
//   frame_done      : one-cycle pulse, the cycle after the out_last beat transfers
//   dbg_state       : frame FSM state
//
// Handshake: a beat moves across an interface on a clock edge where valid and
// ready are both high; valid, once raised, holds with stable data until taken,
// and ready may depend combinationally on downstream ready.
module act_pipe
  import act_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pCHANNELS   = 4,
  parameter int pSHIFT_W    = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      cfg_mode,
  input  logic [pDATA_WIDTH-1:0]          cfg_clip,
  input  logic [pSHIFT_W-1:0]             cfg_shift,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [pCHANNELS*pDATA_WIDTH-1:0] in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [pCHANNELS*pDATA_WIDTH-1:0] out_data,
  output logic                            out_last,
  output logic [CNT_W-1:0]                frame_zero_cnt,
  output logic                            frame_done,
  output act_state_e                      dbg_state
);

  localparam int DW         = pCHANNELS * pDATA_WIDTH;
  localparam int LANE_CNT_W = $clog2(pCHANNELS + 1);

  // Frame FSM and shadow config
  act_state_e                state_q, state_d;
  act_mode_e                 shd_mode_q, shd_mode_d;
  logic [pDATA_WIDTH-1:0]    shd_clip_q, shd_clip_d;
  logic [pSHIFT_W-1:0]       shd_shift_q, shd_shift_d;

  // Pipeline stages
  logic                      s1_valid_q;
  logic [DW-1:0]             s1_data_q;
  logic                      s1_last_q;
  logic [LANE_CNT_W-1:0]     s1_cnt_q;
  logic                      s2_valid_q;
  logic [DW-1:0]             s2_data_q;
  logic                      s2_last_q;
  logic [LANE_CNT_W-1:0]     s2_cnt_q;

  // Counters
  logic [CNT_W-1:0]          run_q, run_d;
  logic [CNT_W-1:0]          zero_cnt_q, zero_cnt_d;
  logic                      done_q;

  // Datapath nets
  act_mode_e                 eff_mode;
  logic [pDATA_WIDTH-1:0]    eff_clip;
  logic [pSHIFT_W-1:0]       eff_shift;
  logic [DW-1:0]             lane_y;
  logic [pCHANNELS-1:0]      lane_alt;
  logic [LANE_CNT_W-1:0]     beat_cnt;
  logic                      s2_ready;
  logic                      s2_load;
  logic                      in_fire;
  logic                      last_xfer;

  assign s2_ready  = !s2_valid_q || out_ready;
  assign s2_load   = s1_valid_q && s2_ready;
  assign in_ready  = !rst && (!s1_valid_q || s2_ready);
  assign in_fire   = in_valid && in_ready;
  assign last_xfer = s2_valid_q && out_ready && s2_last_q;

  // The first beat of a frame already sees the live config; later beats see the shadow.
  assign eff_mode  = (state_q == ST_IDLE) ? act_mode_e'(cfg_mode) : shd_mode_q;
  assign eff_clip  = (state_q == ST_IDLE) ? cfg_clip  : shd_clip_q;
  assign eff_shift = (state_q == ST_IDLE) ? cfg_shift : shd_shift_q;

  for (genvar k = 0; k < pCHANNELS; k++) begin : g_lane
    act_lane #(
      .pDATA_WIDTH (pDATA_WIDTH),
      .pSHIFT_W    (pSHIFT_W)
    ) u_lane (
      .x_i       (in_data[k*pDATA_WIDTH +: pDATA_WIDTH]),
      .mode_i    (eff_mode),
      .clip_i    (eff_clip),
      .shift_i   (eff_shift),
      .y_o       (lane_y[k*pDATA_WIDTH +: pDATA_WIDTH]),
      .altered_o (lane_alt[k])
    );
  end

  always_comb begin
    beat_cnt = '0;
    for (int k = 0; k < pCHANNELS; k++) begin
      beat_cnt = beat_cnt + LANE_CNT_W'(lane_alt[k]);
    end
  end

  always_comb begin
    state_d     = state_q;
    shd_mode_d  = shd_mode_q;
    shd_clip_d  = shd_clip_q;
    shd_shift_d = shd_shift_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          shd_mode_d  = act_mode_e'(cfg_mode);
          shd_clip_d  = cfg_clip;
          shd_shift_d = cfg_shift;
          if (!in_last) state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (in_fire && in_last) state_d = ST_IDLE;
      end
    endcase
  end

  // Non-last beats are folded into the running count as they leave stage 1;
  // the last beat's own count rides in stage 2 and is added at transfer. A
  // next-frame beat entering stage 2 on the same edge starts from zero.
  always_comb begin
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] add;
    base       = last_xfer ? '0 : run_q;
    add        = (s2_load && !s1_last_q) ? CNT_W'(s1_cnt_q) : '0;
    run_d      = sat_add(base, add);
    zero_cnt_d = last_xfer ? sat_add(run_q, CNT_W'(s2_cnt_q)) : zero_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shd_mode_q  <= ACT_BYPASS;
      shd_clip_q  <= '0;
      shd_shift_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_cnt_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_last_q   <= 1'b0;
      s2_cnt_q    <= '0;
      run_q       <= '0;
      zero_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shd_mode_q  <= shd_mode_d;
      shd_clip_q  <= shd_clip_d;
      shd_shift_q <= shd_shift_d;
      run_q       <= run_d;
      zero_cnt_q  <= zero_cnt_d;
      done_q      <= last_xfer;

      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= lane_y;
        s1_last_q  <= in_last;
        s1_cnt_q   <= beat_cnt;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_load) begin
        s2_valid_q <= 1'b1;
        s2_data_q  <= s1_data_q;
        s2_last_q  <= s1_last_q;
        s2_cnt_q   <= s1_cnt_q;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_data       = s2_data_q;
  assign out_last       = s2_last_q;
  assign frame_zero_cnt = zero_cnt_q;
  assign frame_done     = done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_act_pipe.sv
module tb_act_pipe;
  import act_pkg::*;

  localparam int W  = 32;
  localparam int C  = 4;
  localparam int SW = 5;
  localparam int DW = W * C;
  localparam int CW = DW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      cfg_mode;
  logic [W-1:0]    cfg_clip;
  logic [SW-1:0]   cfg_shift;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [15:0]     frame_zero_cnt;
  logic            frame_done;
  act_state_e      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  act_pipe #(.pDATA_WIDTH(W), .pCHANNELS(C), .pSHIFT_W(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_mode       (cfg_mode),
    .cfg_clip       (cfg_clip),
    .cfg_shift      (cfg_shift),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .frame_zero_cnt (frame_zero_cnt),
    .frame_done     (frame_done),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // Reference activation: plain signed arithmetic, leaky via floor division.
  function automatic logic [W-1:0] act_ref(input logic [W-1:0] xb, input int mode,
                                           input logic [W-1:0] clipb, input int shift);
    longint x, clip, d, q;
    x    = longint'($signed(xb));
    clip = longint'($signed(clipb));
    case (mode)
      0: return xb;
      1: return (x < 0) ? '0 : xb;
      2: begin
        if (clip < 0 || x < 0) return '0;
        if (x > clip) return clipb;
        return xb;
      end
      default: begin
        if (x >= 0) return xb;
        if (shift >= W) return '1;
        d = longint'(1) << shift;
        q = x / d;
        if (q * d != x) q = q - 1;
        return q[W-1:0];
      end
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [DW:0]   exp_q[$];
  logic [15:0]   frame_q[$];
  bit            m_in_frame = 0;
  int            m_mode, m_shift;
  logic [W-1:0]  m_clip;
  int            m_run = 0;
  bit            pend = 0;
  logic [15:0]   pend_cnt;
  bit            have_prev = 0;
  bit            prev_valid, prev_ready;
  logic [DW:0]   prev_beat;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      frame_q.delete();
      m_in_frame = 0;
      m_run      = 0;
      pend       = 0;
      have_prev  = 0;
    end else begin
      if (pend) begin
        check("frame_done_pulse", CW'(frame_done), CW'(1));
        check("frame_zero_cnt", CW'(frame_zero_cnt), CW'(pend_cnt));
        pend = 0;
      end else begin
        check("frame_done_quiet", CW'(frame_done), CW'(0));
      end

      if (have_prev && prev_valid && !prev_ready) begin
        check("stall_valid", CW'(out_valid), CW'(1));
        check("stall_hold", {out_last, out_data}, prev_beat);
      end

      if (in_valid && in_ready) begin
        logic [DW-1:0] e;
        logic [W-1:0]  xb, y;
        int            cnt;
        if (!m_in_frame) begin
          m_mode  = int'(cfg_mode);
          m_clip  = cfg_clip;
          m_shift = int'(cfg_shift);
        end
        cnt = 0;
        for (int k = 0; k < C; k++) begin
          xb = in_data[k*W +: W];
          y  = act_ref(xb, m_mode, m_clip, m_shift);
          e[k*W +: W] = y;
          if ((m_mode == 1 || m_mode == 2) && y != xb) cnt++;
        end
        exp_q.push_back({in_last, e});
        m_run += cnt;
        if (in_last) begin
          frame_q.push_back((m_run > 65535) ? 16'hFFFF : 16'(m_run));
          m_run      = 0;
          m_in_frame = 0;
        end else begin
          m_in_frame = 1;
        end
      end

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {out_last, out_data}, '0);
        end else begin
          check("out_beat", {out_last, out_data}, exp_q.pop_front());
        end
        if (out_last) begin
          pend     = 1;
          pend_cnt = (frame_q.size() != 0) ? frame_q.pop_front() : 16'h0;
        end
      end

      have_prev  = 1;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_beat  = {out_last, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input int mode,
                           input int clip, input int shift);
    int t;
    in_data   = d;
    in_last   = last;
    cfg_mode  = 2'(mode);
    cfg_clip  = W'(clip);
    cfg_shift = SW'(shift);
    in_valid  = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        check("accept_timeout", CW'(in_ready), CW'(1));
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_beat(input string name, input logic [DW-1:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({name, "_latency"}, CW'(n), CW'(2));
    check(name, CW'(out_data), CW'(exp));
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name, input logic [15:0] cnt);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (frame_done) break;
      t++;
      if (t > 100) break;
    end
    check({name, "_done"}, CW'(frame_done), CW'(1));
    check(name, CW'(frame_zero_cnt), CW'(cnt));
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cfg_mode = '0; cfg_clip = '0; cfg_shift = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("in_ready_in_rst", CW'(in_ready), CW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", CW'(out_valid), CW'(0));
    check("rst_out_data", {out_last, out_data}, '0);
    check("rst_zero_cnt", CW'(frame_zero_cnt), CW'(0));
    check("rst_state", CW'(dbg_state), CW'(ST_IDLE));
    check("rst_in_ready", CW'(in_ready), CW'(1));
    @(posedge clk); #1;

    // ReLU, single-beat frame
    send_beat(pack4(-5, 0, 7, 32'h80000000), 1'b1, 1, 0, 0);
    expect_beat("relu_beat", pack4(0, 0, 7, 0));
    wait_done("relu_cnt", 16'd2);

    // Clipped ReLU, positive and negative bound
    send_beat(pack4(-1, 3, 6, 100), 1'b1, 2, 6, 0);
    expect_beat("clip_beat", pack4(0, 3, 6, 6));
    wait_done("clip_cnt", 16'd2);
    send_beat(pack4(-1, 3, 6, 100), 1'b1, 2, -4, 0);
    expect_beat("clip_neg_beat", pack4(0, 0, 0, 0));
    wait_done("clip_neg_cnt", 16'd4);

    // Leaky ReLU
    send_beat(pack4(-8, -1, -7, 9), 1'b1, 3, 0, 2);
    expect_beat("leaky_beat", pack4(-2, -1, -2, 9));
    wait_done("leaky_cnt", 16'd0);
    send_beat(pack4(32'h80000000, -5, 5, 0), 1'b1, 3, 0, 31);
    expect_beat("leaky31_beat", pack4(-1, -1, 5, 0));
    wait_done("leaky31_cnt", 16'd0);

    // Config change mid-frame, then back-to-back bypass frame
    fork
      begin
        send_beat(pack4(-1, -2, 3, -4), 1'b0, 1, 0, 0);
        send_beat(pack4(-1, -2, 3, -4), 1'b0, 0, 0, 0);
        send_beat(pack4(-1, -2, 3, -4), 1'b1, 0, 0, 0);
        send_beat(pack4(-9, 8, -7, 6), 1'b0, 0, 0, 0);
        send_beat(pack4(-9, 8, -7, 6), 1'b1, 1, 0, 0);
      end
      begin
        wait_done("midframe_cnt", 16'd9);
        wait_done("bypass_cnt", 16'd0);
      end
    join

    // Random backpressure
    ready_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [DW-1:0] d;
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      for (int k = 0; k < C; k++) begin
        case ($urandom_range(0, 3))
          0:       d[k*W +: W] = W'(int'($urandom_range(0, 40)) - 20);
          1:       d[k*W +: W] = W'($urandom());
          2:       d[k*W +: W] = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
          default: d[k*W +: W] = W'($urandom_range(0, 10));
        endcase
      end
      send_beat(d, 1'($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 40)) - 10, int'($urandom_range(0, 31)));
    end
    send_beat(pack4(1, 2, 3, 4), 1'b1, 0, 0, 0);
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", CW'(exp_q.size()), CW'(0));
    ready_mode = 0;
    repeat (4) begin @(posedge clk); #1; end

    // Reset mid-frame with both stages full
    send_beat(pack4(-5, 0, 7, 32'h80000000), 1'b1, 1, 0, 0);
    wait_done("pre_rst_cnt", 16'd2);
    ready_mode = 2;
    @(posedge clk); #1;
    send_beat(pack4(-3, 4, -5, 6), 1'b0, 1, 0, 0);
    send_beat(pack4(-3, 4, -5, 6), 1'b0, 1, 0, 0);
    in_valid = 1'b1;
    in_data  = pack4(1, 1, 1, 1);
    in_last  = 1'b1;
    @(negedge clk);
    check("full_in_ready", CW'(in_ready), CW'(0));
    check("full_out_valid", CW'(out_valid), CW'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    check("midrst_out_valid", CW'(out_valid), CW'(0));
    check("midrst_zero_cnt", CW'(frame_zero_cnt), CW'(0));
    check("midrst_state", CW'(dbg_state), CW'(ST_IDLE));
    @(posedge clk); #1;
    send_beat(pack4(-1, 3, 6, 100), 1'b0, 2, 6, 0);
    send_beat(pack4(-1, 3, 6, 100), 1'b1, 0, 0, 0);
    wait_done("post_rst_cnt", 16'd4);

    repeat (5) begin @(posedge clk); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
